booth_calc_ctrl: RTL and testbench
==================================

# booth_calc_ctrl

Parametrised keypad calculator controller, the successor to the fixed 2-digit × 1-digit multiplier front-end. It accepts decoded key events and a `set` button, and collects two BCD operands of up to `DIGITS` digits with backspace and clear. It converts each operand to binary iteratively, drives an external sequential multiplier through a start/done handshake, and converts the product back to BCD. The result goes out on a flattened BCD display bus with leading-zero blanking, and the block sits between the keypad decoder and the 7-segment encoders.

## Interface
- `DIGITS`, 4: max BCD digits per operand.
- `BIN_W`, 14: operand binary width. Must satisfy 2^BIN_W > 10^DIGITS−1.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `set` in 1: raw button, level. Synchronised internally and rising-edge detected.
- `key_valid` in 1: one-cycle pulse, key event.
- `key_code` in 4: 0–9 digit, 10 `*` backspace, 11 `#` clear/sign, others ignored.
- `mul_start` out 1: one-cycle start pulse.
- `mul_a`, `mul_b` out BIN_W: operand magnitudes, stable from `mul_start` until `mul_done`.
- `mul_done` in 1: one-cycle pulse, `mul_result` valid.
- `mul_result` in 2*BIN_W: unsigned product.
- `disp_bcd` out 8*DIGITS: displayed digits, digit 0 in LSBs.
- `disp_mask` out 2*DIGITS: per-digit lit enable.
- `disp_sel` out 2: 0 = A, 1 = B, 2 = result, 3 = blank.
- `disp_neg` out 1: minus sign lit.
- `busy` out 1: high in CVA, CVB, MUL, B2D.

## Operation
- States:
  - IDLE → IN_A on set edge.
  - IN_A → CVA on set edge.
  - CVA → IN_B after DIGITS cycles.
  - IN_B → CVB on set edge.
  - CVB → MUL after DIGITS cycles.
  - MUL → B2D on `mul_done`.
  - B2D → SHOW after 2*BIN_W cycles.
  - SHOW → IN_A on set edge. This clears both buffers, counts and signs.
- Entry in IN_A/IN_B acts on the current buffer (16-bit shift style, 4*DIGITS wide) and its digit count:
  - Digit key: shift the buffer left 4 and insert the digit; count+1. Ignored when count == DIGITS.
  - `*` key: shift the buffer right 4; count−1. Ignored when count == 0.
  - `#` key: clear the buffer and count to 0.
- Key events outside IN_A/IN_B are ignored. A set edge in CVA, CVB, MUL or B2D is ignored.
- CVA/CVB conversion: bin = bin*10 + digit, most significant digit first, one digit per cycle, DIGITS cycles. An empty operand converts to 0.
- MUL: `mul_start` is pulsed on the first MUL cycle. A `mul_done` arriving in any other state is ignored.
- B2D: iterative double-dabble of the 2*BIN_W product into 2*DIGITS BCD digits. Only the low 8*DIGITS bits are kept.
- Display:
  - `disp_sel` = 0 in IN_A/CVA, 1 in IN_B/CVB/MUL, 2 in B2D/SHOW (bus updates in SHOW only), 3 in IDLE.
  - Operand mask = low `count` digits; digit 0 is always lit.
  - Result mask covers digit 0 up to the most significant nonzero digit.
- Simultaneous set edge and `key_valid` in IN_A/IN_B: the key is applied and included in the conversion.

## Timing
- Reset values: state IDLE, buffers and counts 0, `mul_start` 0, `mul_a`/`mul_b` 0, `disp_bcd` 0, `disp_mask` 0, `disp_sel` 3, `disp_neg` 0, `busy` 0.
- Reset mid-operation aborts immediately. A later `mul_done` is ignored.
- Set edge latency: rising `set` to state change is 3 cycles (2-flop synchroniser plus edge register).
- Key applied on the edge following `key_valid`.
- From the set edge in IN_B to `mul_start`: DIGITS+1 cycles.
- From `mul_done` to SHOW with a valid display: 2*BIN_W+1 cycles.
- Outputs are registered.

## Configuration
- `BOOTH_CALC_SIGNED_EN` defined:
  - `#` toggles the current operand's sign instead of clearing.
  - `disp_neg` = sign of the displayed operand; for the result, signA ^ signB, forced 0 when the result is 0.
  - Magnitudes are still sent to the multiplier.
- Not defined: `#` clears, and `disp_neg` is tied 0.

## Structure
- Package `booth_calc_pkg` holds:
  - the state enum;
  - key code constants (KEY_BS = 10, KEY_HASH = 11);
  - `disp_sel` encodings.
- Sub-module `bin_bcd_iter`: parametrised iterative double-dabble with start/done.

## Test plan
All scenarios use DIGITS = 4, BIN_W = 14.
- Keys 1, 2, 3, 4, set, keys 5, 6, set, model returns 69104 → `mul_a` = 1234, `mul_b` = 56; SHOW `disp_bcd` = 0x00069104, `disp_mask` = 0x1F.
- Keys 1, 2, 3, `*`, 4 in IN_A → buffer 0x0124, `mul_a` = 124.
- Keys 1, 2, 3, 4, 5 → fifth key ignored, `mul_a` = 1234. `*` with count 0 leaves mask 0x01.
- Set with an empty B → `mul_b` = 0; result 0, mask 0x01, `disp_neg` 0.
- `rst_n` low during B2D → all outputs at reset values the same cycle; a late `mul_done` has no effect.
- With the macro: A = 12 with `#`, B = 3, result 36 → `disp_neg` = 1. Without the macro, `#` clears A.

Source files
------------

// File: rtl/booth_calc_pkg.sv
// booth_calc_pkg: shared states, key codes and display selector encodings
package booth_calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_IN_A, ST_CVA, ST_IN_B, ST_CVB, ST_MUL, ST_B2D, ST_SHOW
    } state_t;

    localparam logic [3:0] KEY_BS   = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam logic [1:0] SEL_A     = 2'd0;
    localparam logic [1:0] SEL_B     = 2'd1;
    localparam logic [1:0] SEL_RES   = 2'd2;
    localparam logic [1:0] SEL_BLANK = 2'd3;

endpackage

// File: rtl/bin_bcd_iter.sv
// bin_bcd_iter: iterative double-dabble, one input bit per cycle; digits above ND are dropped
module bin_bcd_iter #(
    parameter int IN_W = 28,
    parameter int ND   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IN_W-1:0]   bin,
    output logic              done,
    output logic [4*ND-1:0]   bcd
);

    localparam int CW = $clog2(IN_W);

    logic [IN_W-1:0] sh;
    logic [CW-1:0]   cnt;
    logic            run;
    logic [4*ND-1:0] adj;

    // add 3 to every digit of 5 or more before the next shift
    always_comb begin
        adj = bcd;
        for (int i = 0; i < ND; i++)
            adj[4*i +: 4] = (bcd[4*i +: 4] > 4'd4) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // load on start, then shift one binary bit into the BCD register per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sh, cnt, run, done, bcd} <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh  <= bin;
                bcd <= '0;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                bcd <= {adj[4*ND-2:0], sh[IN_W-1]};
                sh  <= sh << 1;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(IN_W - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/booth_calc_ctrl.sv
// booth_calc_ctrl: keypad calculator controller; define BOOTH_CALC_SIGNED_EN for signed operands via '#'
module booth_calc_ctrl
    import booth_calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic                  mul_start,
    output logic [BIN_W-1:0]      mul_a,
    output logic [BIN_W-1:0]      mul_b,
    input  logic                  mul_done,
    input  logic [2*BIN_W-1:0]    mul_result,
    output logic [8*DIGITS-1:0]   disp_bcd,
    output logic [2*DIGITS-1:0]   disp_mask,
    output logic [1:0]            disp_sel,
    output logic                  disp_neg,
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    state_t state, nxt;
    logic s1, s2, s3, set_edge, editing, b2d_done, show, lit, neg_d, busy_d;
    logic [BW-1:0] buf_a, buf_b, ed_buf, nb, cv_buf, cv_sh;
    logic [CW-1:0] cnt_a, cnt_b, ed_cnt, nc, cyc, idx;
    logic [BIN_W-1:0] acc_in, acc_nx;
    logic [8*DIGITS-1:0] res_bcd, bcd_d;
    logic [2*DIGITS-1:0] res_mask, mask_d;
    logic [1:0] sel_d;

    function automatic logic [DIGITS-1:0] low_mask(input logic [CW-1:0] n);
        for (int i = 0; i < DIGITS; i++)
            low_mask[i] = (i == 0) || (i < int'(n));
    endfunction

    // two-flop synchroniser plus edge register for the set button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {s1, s2, s3} <= '0;
        else        {s1, s2, s3} <= {set, s1, s2};
    end

    assign set_edge = s2 & ~s3;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nxt;
    end

    // next-state logic
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: nxt = set_edge ? ST_IN_A : state;
            ST_IN_A: nxt = set_edge ? ST_CVA : state;
            ST_CVA:  nxt = (cyc == LAST) ? ST_IN_B : state;
            ST_IN_B: nxt = set_edge ? ST_CVB : state;
            ST_CVB:  nxt = (cyc == LAST) ? ST_MUL : state;
            ST_MUL:  nxt = mul_done ? ST_B2D : state;
            ST_B2D:  nxt = b2d_done ? ST_SHOW : state;
            ST_SHOW: nxt = set_edge ? ST_IN_A : state;
        endcase
    end

    assign editing = key_valid && (state == ST_IN_A || state == ST_IN_B);
    assign ed_buf  = (state == ST_IN_B) ? buf_b : buf_a;
    assign ed_cnt  = (state == ST_IN_B) ? cnt_b : cnt_a;

    // effect of the current key on the operand being edited
    always_comb begin
        nb = ed_buf;
        nc = ed_cnt;
        if (key_code < 4'd10 && ed_cnt != FULL) begin
            nb = {ed_buf[BW-5:0], key_code};
            nc = ed_cnt + 1'b1;
        end else if (key_code == KEY_BS && ed_cnt != '0) begin
            nb = ed_buf >> 4;
            nc = ed_cnt - 1'b1;
`ifdef BOOTH_CALC_SIGNED_EN
        end
`else
        end else if (key_code == KEY_HASH) begin
            nb = '0;
            nc = '0;
        end
`endif
    end

    // operand buffers: cleared when a new calculation starts from SHOW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {buf_a, buf_b, cnt_a, cnt_b} <= '0;
        end else if (state == ST_SHOW && set_edge) begin
            {buf_a, buf_b, cnt_a, cnt_b} <= '0;
        end else if (editing) begin
            if (state == ST_IN_B) {buf_b, cnt_b} <= {nb, nc};
            else                  {buf_a, cnt_a} <= {nb, nc};
        end
    end

`ifdef BOOTH_CALC_SIGNED_EN
    logic sign_a, sign_b;

    // operand signs toggled by '#'
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sign_a, sign_b} <= '0;
        end else if (state == ST_SHOW && set_edge) begin
            {sign_a, sign_b} <= '0;
        end else if (editing && key_code == KEY_HASH) begin
            if (state == ST_IN_B) sign_b <= ~sign_b;
            else                  sign_a <= ~sign_a;
        end
    end
`endif

    assign cv_buf = (state == ST_CVB) ? buf_b : buf_a;
    assign idx    = LAST - cyc;
    assign cv_sh  = cv_buf >> {idx, 2'b00};
    assign acc_in = (cyc == '0) ? '0 : (state == ST_CVB) ? mul_b : mul_a;
    assign acc_nx = acc_in * BIN_W'(10) + BIN_W'(cv_sh[3:0]);

    // BCD-to-binary conversion, most significant digit first, and multiplier start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {mul_start, mul_a, mul_b, cyc} <= '0;
        end else begin
            mul_start <= (state == ST_CVB) && (cyc == LAST);
            if (state == ST_CVA || state == ST_CVB) cyc <= (cyc == LAST) ? '0 : cyc + 1'b1;
            if (state == ST_CVA) mul_a <= acc_nx;
            if (state == ST_CVB) mul_b <= acc_nx;
        end
    end

    bin_bcd_iter #(.IN_W(2 * BIN_W), .ND(2 * DIGITS)) u_b2d (
        .clk   (clk),
        .rst_n (rst_n),
        .start (state == ST_MUL && mul_done),
        .bin   (mul_result),
        .done  (b2d_done),
        .bcd   (res_bcd)
    );

    // result mask lights digit 0 up to the highest nonzero digit
    always_comb begin
        lit = 1'b0;
        res_mask = '0;
        for (int i = 2 * DIGITS - 1; i >= 0; i--) begin
            lit = lit | (res_bcd[4*i +: 4] != 4'd0) | (i == 0);
            res_mask[i] = lit;
        end
    end

    // output decode from the next state; the result bus only refreshes on entering SHOW
    always_comb begin
        sel_d  = (nxt == ST_IDLE) ? SEL_BLANK :
                 (nxt == ST_IN_A || nxt == ST_CVA) ? SEL_A :
                 (nxt == ST_IN_B || nxt == ST_CVB || nxt == ST_MUL) ? SEL_B : SEL_RES;
        busy_d = nxt inside {ST_CVA, ST_CVB, ST_MUL, ST_B2D};
        show   = nxt == ST_SHOW;
        bcd_d  = (sel_d == SEL_A) ? (8*DIGITS)'(buf_a) :
                 (sel_d == SEL_B) ? (8*DIGITS)'(buf_b) :
                 (sel_d == SEL_BLANK) ? '0 : show ? res_bcd : disp_bcd;
        mask_d = (sel_d == SEL_A) ? (2*DIGITS)'(low_mask(cnt_a)) :
                 (sel_d == SEL_B) ? (2*DIGITS)'(low_mask(cnt_b)) :
                 (sel_d == SEL_BLANK) ? '0 : show ? res_mask : disp_mask;
`ifdef BOOTH_CALC_SIGNED_EN
        neg_d  = (sel_d == SEL_A) ? sign_a :
                 (sel_d == SEL_B) ? sign_b :
                 (sel_d == SEL_BLANK) ? 1'b0 :
                 show ? ((sign_a ^ sign_b) && res_bcd != '0) : disp_neg;
`else
        neg_d  = 1'b0;
`endif
    end

    // registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bcd  <= '0;
            disp_mask <= '0;
            disp_sel  <= SEL_BLANK;
            disp_neg  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            disp_bcd  <= bcd_d;
            disp_mask <= mask_d;
            disp_sel  <= sel_d;
            disp_neg  <= neg_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_booth_calc_ctrl.sv
// tb_booth_calc_ctrl: scoreboard bench with directed keypad sequences and a multiplier model
module tb_booth_calc_ctrl;

    typedef struct { logic [13:0] a; logic [13:0] b; } op_t;
    typedef struct { logic [31:0] bcd; logic [7:0] mask; logic neg; } res_t;

`ifdef BOOTH_CALC_SIGNED_EN
    localparam logic SGN = 1'b1;
`else
    localparam logic SGN = 1'b0;
`endif

    logic        clk = 0, rst_n = 0, set = 0, key_valid = 0, mul_done = 0;
    logic [3:0]  key_code = 0;
    logic [27:0] mul_result = '0;
    logic        mul_start, disp_neg, busy;
    logic [13:0] mul_a, mul_b;
    logic [31:0] disp_bcd;
    logic [7:0]  disp_mask;
    logic [1:0]  disp_sel;

    int   total = 0, bad = 0, shows = 0;
    logic pb = 0, late_req = 0, late_done = 0;
    op_t  op_q[$];
    res_t res_q[$];

    booth_calc_ctrl #(.DIGITS(4), .BIN_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .set(set), .key_valid(key_valid), .key_code(key_code),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
        .mul_result(mul_result), .disp_bcd(disp_bcd), .disp_mask(disp_mask),
        .disp_sel(disp_sel), .disp_neg(disp_neg), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        key_code = k;
        key_valid = 1;
        @(negedge clk);
        key_valid = 0;
        tick(2);
    endtask

    task automatic push_set();
        set = 1;
        tick(3);
        set = 0;
        tick(8);
    endtask

    task automatic expect_op(input logic [13:0] a, input logic [13:0] b);
        op_t o;
        o.a = a;
        o.b = b;
        op_q.push_back(o);
    endtask

    task automatic expect_res(input logic [31:0] bcd, input logic [7:0] mask, input logic neg);
        res_t r;
        r.bcd = bcd;
        r.mask = mask;
        r.neg = neg;
        res_q.push_back(r);
    endtask

    task automatic wait_show(input int n0);
        int t = 0;
        while (shows == n0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (shows == n0) begin
            total++;
            bad++;
            $display("FAIL show_timeout: no result after %0d cycles", t);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sel"}, disp_sel, 2'd3);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_bcd"}, disp_bcd, 0);
        chk({tag, "_mask"}, disp_mask, 0);
        chk({tag, "_start"}, mul_start, 0);
        chk({tag, "_a"}, mul_a, 0);
        chk({tag, "_b"}, mul_b, 0);
        chk({tag, "_neg"}, disp_neg, 0);
    endtask

    initial begin
        tick(3);
        chk_reset("rst");
        rst_n = 1;
        tick(2);
        fork
            // monitor: compare operands at mul_start and the result when busy falls in SHOW
            forever begin
                @(negedge clk);
                if (mul_start) begin
                    if (op_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL mul_start: got unexpected start expected none");
                    end else begin
                        op_t o;
                        o = op_q.pop_front();
                        chk("mul_a", mul_a, o.a);
                        chk("mul_b", mul_b, o.b);
                    end
                end
                if (pb && !busy && disp_sel == 2'd2) begin
                    if (res_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL result: got unexpected result %0h expected none", disp_bcd);
                    end else begin
                        res_t r;
                        r = res_q.pop_front();
                        chk("res_bcd", disp_bcd, r.bcd);
                        chk("res_mask", disp_mask, r.mask);
                        chk("res_neg", disp_neg, r.neg);
                    end
                    shows++;
                end
                pb = busy;
            end
            // external multiplier model
            forever begin
                @(negedge clk);
                if (late_req && !late_done) begin
                    late_done = 1;
                    mul_result = 28'd56;
                    mul_done = 1;
                    @(negedge clk);
                    mul_done = 0;
                end else if (mul_start) begin
                    tick(3);
                    mul_result = 28'(mul_a) * 28'(mul_b);
                    mul_done = 1;
                    @(negedge clk);
                    mul_done = 0;
                end
            end
            begin
                int n, t;
                // 1234 x 56
                push_set();
                for (int i = 1; i <= 4; i++) press(4'(i));
                chk("a_bcd", disp_bcd, 32'h1234);
                chk("a_mask", disp_mask, 8'h0F);
                chk("a_sel", disp_sel, 2'd0);
                expect_op(14'd1234, 14'd56);
                expect_res(32'h00069104, 8'h1F, 1'b0);
                push_set();
                press(4'd5);
                press(4'd6);
                chk("b_bcd", disp_bcd, 32'h56);
                chk("b_mask", disp_mask, 8'h03);
                chk("b_sel", disp_sel, 2'd1);
                n = shows;
                push_set();
                wait_show(n);
                // backspace, then empty B
                push_set();
                chk("clr_bcd", disp_bcd, 0);
                chk("clr_mask", disp_mask, 8'h01);
                press(4'd1);
                press(4'd2);
                press(4'd3);
                press(4'd10);
                press(4'd4);
                chk("bs_bcd", disp_bcd, 32'h0124);
                chk("bs_mask", disp_mask, 8'h07);
                expect_op(14'd124, 14'd0);
                expect_res(32'h0, 8'h01, 1'b0);
                push_set();
                n = shows;
                push_set();
                wait_show(n);
                // overflow of digits and backspace at count 0
                push_set();
                for (int i = 1; i <= 5; i++) press(4'(i));
                chk("full_bcd", disp_bcd, 32'h1234);
                chk("full_mask", disp_mask, 8'h0F);
                repeat (5) press(4'd10);
                chk("empty_bcd", disp_bcd, 0);
                chk("empty_mask", disp_mask, 8'h01);
                for (int i = 1; i <= 5; i++) press(4'(i));
                expect_op(14'd1234, 14'd9);
                expect_res(32'h00011106, 8'h1F, 1'b0);
                push_set();
                press(4'd9);
                n = shows;
                push_set();
                wait_show(n);
                // '#' key
                push_set();
                press(4'd1);
                press(4'd2);
                press(4'd11);
`ifdef BOOTH_CALC_SIGNED_EN
                chk("hash_bcd", disp_bcd, 32'h12);
                chk("hash_mask", disp_mask, 8'h03);
                chk("hash_neg", disp_neg, 1);
`else
                chk("hash_bcd", disp_bcd, 0);
                chk("hash_mask", disp_mask, 8'h01);
                chk("hash_neg", disp_neg, 0);
                press(4'd1);
                press(4'd2);
`endif
                expect_op(14'd12, 14'd3);
                expect_res(32'h36, 8'h03, SGN);
                push_set();
                press(4'd3);
                n = shows;
                push_set();
                wait_show(n);
                // reset during B2D, then a stray mul_done
                push_set();
                press(4'd7);
                push_set();
                press(4'd8);
                expect_op(14'd7, 14'd8);
                push_set();
                t = 0;
                while (!(busy && disp_sel == 2'd2) && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                chk("in_b2d", {31'b0, busy && disp_sel == 2'd2}, 1);
                tick(3);
                #2 rst_n = 0;
                #1 chk_reset("abort");
                @(negedge clk);
                rst_n = 1;
                late_req = 1;
                tick(60);
                chk("late_busy", busy, 0);
                chk("late_sel", disp_sel, 2'd3);
                chk("late_bcd", disp_bcd, 0);
                chk("late_mask", disp_mask, 0);
                chk("ops_left", op_q.size(), 0);
                chk("res_left", res_q.size(), 0);
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
